alu_lockstep_ctrl: RTL and testbench

//  Initiator side of the dual-ALU lockstep pair. Accepts one op per request
//  (A, B, sel), drives identical operands to both ALU copies, samples both

---
 rtl/alu_lockstep_pkg.sv | 21 ++
 rtl/alu_lockstep_ctrl_compare.sv | 16 +
 rtl/alu_lockstep_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_lockstep_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lockstep_pkg.sv
// alu_lockstep_pkg: shared types and constants for the lockstep ALU controller.
`default_nettype none
package alu_lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  // Enough for MAX_RETRY up to 7.
  localparam int RETRY_W = 3;

endpackage
`default_nettype wire

// File: rtl/alu_lockstep_ctrl_compare.sv
// lockstep_compare: flags any disagreement between the two registered ALU results.
`default_nettype none
module lockstep_compare #(
  parameter int W = 8
) (
  input  logic [W-1:0] out1,
  input  logic [W-1:0] out2,
  input  logic         carry1,
  input  logic         carry2,
  output logic         mism
);

  assign mism = (|(out1 ^ out2)) | (carry1 ^ carry2);

endmodule
`default_nettype wire

// File: rtl/alu_lockstep_ctrl.sv
// alu_lockstep_ctrl: drives two ALU copies, compares results, retries on
// disagreement and returns one checked response with fault bookkeeping.
`default_nettype none
module alu_lockstep_ctrl
  import alu_lockstep_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [1:0]       req_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [7:0]       A0,
  output logic [7:0]       B0,
  output logic [7:0]       A1,
  output logic [7:0]       B1,
  output logic [1:0]       ALU_Sel1,
  output logic [1:0]       ALU_Sel2,
  input  logic [7:0]       ALU_Out1,
  input  logic [7:0]       ALU_Out2,
  input  logic             CarryOut1,
  input  logic             CarryOut2,
  input  logic             inj_en,
  input  logic             inj_sticky,
  input  logic [7:0]       inj_mask,
  input  logic             clr_err,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             err_sticky
);

  localparam logic [RETRY_W-1:0] MAX_R   = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  state_t               state;
  logic [7:0]           op_a;
  logic                 inj_sticky_q;
  logic [7:0]           mask_q;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [7:0]           out1_q;
  logic [7:0]           out2_q;
  logic                 carry1_q;
  logic                 carry2_q;
  logic                 mism;

  lockstep_compare #(.W(8)) u_compare (
    .out1   (out1_q),
    .out2   (out2_q),
    .carry1 (carry1_q),
    .carry2 (carry2_q),
    .mism   (mism)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_result   <= 8'h00;
      rsp_carry    <= 1'b0;
      rsp_err      <= 1'b0;
      A0           <= 8'h00;
      B0           <= 8'h00;
      A1           <= 8'h00;
      B1           <= 8'h00;
      ALU_Sel1     <= 2'b00;
      ALU_Sel2     <= 2'b00;
      op_a         <= 8'h00;
      inj_sticky_q <= 1'b0;
      mask_q       <= 8'h00;
      retry_cnt    <= '0;
      out1_q       <= 8'h00;
      out2_q       <= 8'h00;
      carry1_q     <= 1'b0;
      carry2_q     <= 1'b0;
      fault_cnt    <= '0;
      err_sticky   <= 1'b0;
    end else begin
      // A set later in this block overrides the clear.
      if (clr_err) err_sticky <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_a         <= req_a;
            inj_sticky_q <= inj_sticky;
            mask_q       <= inj_mask;
            retry_cnt    <= '0;
            // Drive operands are loaded here so they are stable for the EXEC cycle.
            A0           <= req_a;
            B0           <= req_b;
            A1           <= req_a ^ ((inj_en | inj_sticky) ? inj_mask : 8'h00);
            B1           <= req_b;
            ALU_Sel1     <= req_sel;
            ALU_Sel2     <= req_sel;
            req_ready    <= 1'b0;
            state        <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          out1_q   <= ALU_Out1;
          out2_q   <= ALU_Out2;
          carry1_q <= CarryOut1;
          carry2_q <= CarryOut2;
          state    <= ST_CHECK;
        end

        ST_CHECK: begin
          if (!mism) begin
            rsp_valid  <= 1'b1;
            rsp_result <= out1_q;
            rsp_carry  <= carry1_q;
            rsp_err    <= 1'b0;
            state      <= ST_RESP;
          end else begin
            if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + CNT_W'(1);
            if (retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              A1        <= op_a ^ (inj_sticky_q ? mask_q : 8'h00);
              state     <= ST_EXEC;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_result <= out1_q;
              rsp_carry  <= carry1_q;
              rsp_err    <= 1'b1;
              err_sticky <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_lockstep_ctrl.sv
// tb_alu_lockstep_ctrl: randomized scoreboard bench for the lockstep ALU controller.
`default_nettype none
module tb_alu_lockstep_ctrl;

  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [1:0] req_sel;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_err;
  logic [7:0] A0, B0, A1, B1;
  logic [1:0] ALU_Sel1, ALU_Sel2;
  logic [7:0] ALU_Out1, ALU_Out2;
  logic       CarryOut1, CarryOut2;
  logic       inj_en, inj_sticky;
  logic [7:0] inj_mask;
  logic       clr_err;
  logic [7:0] fault_cnt;
  logic       err_sticky;

  alu_lockstep_ctrl #(.MAX_RETRY(MAX_RETRY), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .ALU_Sel1(ALU_Sel1), .ALU_Sel2(ALU_Sel2),
    .ALU_Out1(ALU_Out1), .ALU_Out2(ALU_Out2),
    .CarryOut1(CarryOut1), .CarryOut2(CarryOut2),
    .inj_en(inj_en), .inj_sticky(inj_sticky), .inj_mask(inj_mask),
    .clr_err(clr_err), .fault_cnt(fault_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}; subtract carry is the borrow.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [8:0] alu1, alu2;
  assign alu1 = alu_ref(A0, B0, ALU_Sel1);
  assign alu2 = alu_ref(A1, B1, ALU_Sel2);
  assign ALU_Out1  = alu1[7:0];
  assign CarryOut1 = alu1[8];
  assign ALU_Out2  = alu2[7:0];
  assign CarryOut2 = alu2[8];

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       err;
    int         lat;
    logic [7:0] fc;
    logic       es;
    int         issue;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_fc = 0;
  logic model_es = 1'b0;
  int   force_hold = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                       input logic en, input logic st, input logic [7:0] m,
                       input int hold, input logic clr);
    exp_t       e;
    logic [8:0] r1, r2;
    logic [7:0] mm;
    int         nmis;
    int         attempts;
    wait_ready();
    if (clr) begin
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      model_es = 1'b0;
      chk("err_sticky_cleared", {31'd0, err_sticky}, 32'd0);
    end
    r1 = alu_ref(a, b, s);
    nmis = 0;
    e.err = 1'b1;
    for (int att = 0; att <= MAX_RETRY; att++) begin
      mm = (st || (en && att == 0)) ? m : 8'h00;
      r2 = alu_ref(a ^ mm, b, s);
      if (r2 == r1) begin
        e.err = 1'b0;
        break;
      end
      nmis++;
    end
    attempts = e.err ? MAX_RETRY + 1 : nmis + 1;
    model_fc = (model_fc + nmis > 255) ? 255 : model_fc + nmis;
    if (e.err) model_es = 1'b1;
    e.res   = r1[7:0];
    e.carry = r1[8];
    e.lat   = 1 + 2 * attempts;
    e.fc    = model_fc[7:0];
    e.es    = model_es;
    e.issue = ncyc;
    force_hold = hold;
    sb.push_back(e);
    req_a = a; req_b = b; req_sel = s;
    inj_en = en; inj_sticky = st; inj_mask = m;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_sel = 2'($urandom);
    inj_en = 1'b0; inj_sticky = 1'b0; inj_mask = 8'($urandom);
  endtask

  task automatic abort_in(input int extra);
    wait_ready();
    req_a = 8'h10; req_b = 8'h20; req_sel = 2'b00;
    inj_en = 1'b0; inj_sticky = 1'b1; inj_mask = 8'h01;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; inj_sticky = 1'b0;
    repeat (extra) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_fc = 0;
    model_es = 1'b0;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_fault_cnt", {24'd0, fault_cnt}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  // Monitor: owns rsp_ready, pops the scoreboard on each accepted response.
  initial begin
    int   hold_left;
    logic in_rsp;
    logic idle_chk;
    in_rsp = 1'b0; idle_chk = 1'b0; hold_left = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 1'b0; idle_chk = 1'b0; rsp_ready = 1'b0;
      end else begin
        if (idle_chk) begin
          chk("idle_after_accept", {31'd0, req_ready}, 32'd1);
          idle_chk = 1'b0;
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            if (sb.size() == 0) begin
              chk("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
              hold_left = 0;
            end else begin
              cur = sb[0];
              chk("rsp_latency", 32'(ncyc - cur.issue), 32'(cur.lat));
              chk("rsp_result", {24'd0, rsp_result}, {24'd0, cur.res});
              chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, cur.carry});
              chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
              chk("fault_cnt", {24'd0, fault_cnt}, {24'd0, cur.fc});
              chk("err_sticky", {31'd0, err_sticky}, {31'd0, cur.es});
              hold_left = (force_hold >= 0) ? force_hold : $urandom_range(0, 2);
              in_rsp = 1'b1;
            end
          end else begin
            chk("hold_result", {24'd0, rsp_result}, {24'd0, cur.res});
            chk("hold_carry", {31'd0, rsp_carry}, {31'd0, cur.carry});
            chk("hold_err", {31'd0, rsp_err}, {31'd0, cur.err});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
          end
          if (hold_left == 0) begin
            rsp_ready = 1'b1;
            if (in_rsp) void'(sb.pop_front());
            in_rsp = 1'b0;
            idle_chk = 1'b1;
          end else begin
            rsp_ready = 1'b0;
            hold_left--;
          end
        end else begin
          rsp_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_sel = 2'b00;
    inj_en = 1'b0; inj_sticky = 1'b0; inj_mask = 8'h00; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_fault_cnt", {24'd0, fault_cnt}, 32'd0);
    chk("reset_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("reset_A1", {24'd0, A1}, 32'd0);
    rst = 1'b0;

    issue(8'h7F, 8'h01, 2'b00, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    issue(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 8'h00, 1, 1'b0);
    issue(8'h05, 8'h07, 2'b01, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    issue(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    issue(8'hF0, 8'h0C, 2'b11, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    issue(8'h10, 8'h20, 2'b00, 1'b1, 1'b0, 8'h01, 0, 1'b0);
    issue(8'h10, 8'h20, 2'b00, 1'b0, 1'b1, 8'h01, 0, 1'b0);
    issue(8'h33, 8'h44, 2'b00, 1'b1, 1'b1, 8'h80, 4, 1'b1);
    issue(8'h01, 8'h02, 2'b10, 1'b0, 1'b0, 8'h00, 0, 1'b1);

    abort_in(0);
    abort_in(1);

    // Every sticky add attempt disagrees, so this drives fault_cnt past saturation.
    for (int i = 0; i < 90; i++)
      issue(8'($urandom), 8'($urandom), 2'b00, 1'b0, 1'b1,
            8'($urandom_range(1, 255)), -1, 1'b0);

    for (int i = 0; i < 60; i++)
      issue(8'($urandom), 8'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            8'($urandom), -1, ($urandom_range(0, 7) == 0));

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
